// File: rtl/axi_lite_rd_arbiter_pkg.sv
// Shared definitions for the AXI4-Lite read arbiter: FSM state encoding,
// master index constants and AXI response codes.
package axi_lite_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic MST_IFU = 1'b0;
  localparam logic MST_LSU = 1'b1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_rd_arbiter_if.sv
// AXI4-Lite read channel (AR + R) bundle.
// Ports (signals):
//   arvalid/araddr/rready : driven by the master side
//   arready/rvalid/rdata/rresp : driven by the slave side
// Modports:
//   master : the requester's view (drives AR, accepts R)
//   slave  : the responder's view (accepts AR, drives R)
interface axi_lite_rd_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;

  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_rd_arbiter_rr_arb2.sv
// Two-requester round-robin pick, purely combinational.
// Ports:
//   req     : request vector, bit i = requester i
//   last    : index of the most recently served requester
//   gnt_idx : index of the winner (only meaningful when req != 0)
module rr_arb2
  import axi_lite_rd_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_idx
);

  always_comb begin
    gnt_idx = MST_IFU;
    case (req)
      2'b01:   gnt_idx = MST_IFU;
      2'b10:   gnt_idx = MST_LSU;
      // Contention: whoever was not served last wins.
      2'b11:   gnt_idx = ~last;
      default: gnt_idx = MST_IFU;
    endcase
  end

endmodule

// File: rtl/axi_lite_rd_arbiter.sv
// Two-master, one-slave AXI4-Lite read-channel arbiter (IFU = m0, LSU = m1).
// One transaction outstanding at a time; the grant is taken in IDLE, held from
// the AR handshake until the R handshake, then round-robin priority flips.
// Ports:
//   aclk   : clock, rising edge
//   areset : asynchronous active-high reset
//   m0, m1 : slave-side read channels facing the IFU and LSU
//   s      : master-side read channel facing the SRAM
module axi_lite_rd_arbiter
  import axi_lite_rd_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  axi_lite_rd_arbiter_if.slave  m0,
  axi_lite_rd_arbiter_if.slave  m1,
  axi_lite_rd_arbiter_if.master s
);

  state_e            state_q;
  logic              grant_q;
  logic              last_q;
  logic              gnt_idx;
  logic [1:0]        req;
  logic [ADDR_W-1:0] araddr_sel;
  logic [DATA_W-1:0] rdata_sel;

  assign req = {m1.arvalid, m0.arvalid};

  rr_arb2 u_rr_arb2 (
    .req     (req),
    .last    (last_q),
    .gnt_idx (gnt_idx)
  );

  // Arbitration is registered in IDLE so no request reaches the slave
  // combinationally; everything after that muxes on grant_q.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= MST_IFU;
      last_q  <= MST_LSU;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q <= gnt_idx;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (s.arvalid && s.arready) state_q <= DATA;
        end
        DATA: begin
          if (s.rvalid && s.rready) begin
            last_q  <= grant_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    araddr_sel = (grant_q == MST_LSU) ? m1.araddr : m0.araddr;
    rdata_sel  = s.rdata;

    s.arvalid  = 1'b0;
    s.araddr   = '0;
    s.rready   = 1'b0;
    m0.arready = 1'b0;
    m1.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m1.rvalid  = 1'b0;
    m0.rdata   = '0;
    m1.rdata   = '0;
    m0.rresp   = OKAY;
    m1.rresp   = OKAY;

    case (state_q)
      ADDR: begin
        s.araddr = araddr_sel;
        if (grant_q == MST_LSU) begin
          s.arvalid  = m1.arvalid;
          m1.arready = s.arready;
        end else begin
          s.arvalid  = m0.arvalid;
          m0.arready = s.arready;
        end
      end
      DATA: begin
        if (grant_q == MST_LSU) begin
          m1.rvalid = s.rvalid;
          m1.rdata  = rdata_sel;
          m1.rresp  = s.rresp;
          s.rready  = m1.rready;
        end else begin
          m0.rvalid = s.rvalid;
          m0.rdata  = rdata_sel;
          m0.rresp  = s.rresp;
          s.rready  = m0.rready;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_rd_arbiter.sv
// Self-checking bench for axi_lite_rd_arbiter: directed scenarios plus a
// randomized run checked against a round-robin reference model.
module tb_axi_lite_rd_arbiter;

  logic aclk;
  logic areset;
  int   checks = 0;
  int   errors = 0;
  int   last_m;       // model: index of the master served most recently

  axi_lite_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  axi_lite_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  axi_lite_rd_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  axi_lite_rd_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk   (aclk),
    .areset (areset),
    .m0     (m0_if),
    .m1     (m1_if),
    .s      (s_if)
  );

  initial begin
    aclk = 0;
    forever #5 aclk = ~aclk;
  end

  // Round-robin rule: a lone requester wins; on contention the one not served last.
  function automatic int predict(input bit p0, input bit p1, input int last);
    if (p0 && p1) return 1 - last;
    return p1 ? 1 : 0;
  endfunction

  task automatic set_rready(input int mst, input logic v);
    if (mst == 1) m1_if.rready = v;
    else m0_if.rready = v;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1;
    @(negedge aclk);
    areset = 0;
    last_m = 1;
  endtask

  // Plays the SRAM for one transaction, starting at a negedge after requests are
  // driven. Returns observations only; callers make the comparisons.
  task automatic serve(input int ar_stall, input int rr_stall, input logic [31:0] data,
                       input logic [1:0] resp, output int lat, output int mst,
                       output logic [31:0] addr, output logic [31:0] rd,
                       output logic [1:0] rr, output bit leak, output bit mirror_ok,
                       output bit hold_ok);
    lat = 0; mst = -1; addr = '0; rd = '0; rr = '0;
    leak = 0; mirror_ok = 1; hold_ok = 1;
    #1;
    while (!s_if.arvalid && lat < 20) begin
      @(negedge aclk); #1;
      lat++;
    end
    if (!s_if.arvalid) return;
    addr = s_if.araddr;
    repeat (ar_stall) begin
      if (m0_if.arready || m1_if.arready) mirror_ok = 0;
      @(negedge aclk); #1;
    end
    s_if.arready = 1; #1;
    if (m0_if.arready && !m1_if.arready) mst = 0;
    else if (m1_if.arready && !m0_if.arready) mst = 1;
    else mirror_ok = 0;
    @(negedge aclk);
    s_if.arready = 0;
    if (mst == 1) m1_if.arvalid = 0;
    else m0_if.arvalid = 0;
    s_if.rvalid = 1; s_if.rdata = data; s_if.rresp = resp;
    set_rready(mst, 0);
    #1;
    repeat (rr_stall) begin
      if (mst == 1) begin
        if (!m1_if.rvalid || m1_if.rdata !== data) hold_ok = 0;
      end else begin
        if (!m0_if.rvalid || m0_if.rdata !== data) hold_ok = 0;
      end
      if (s_if.rready) hold_ok = 0;
      @(negedge aclk); #1;
    end
    set_rready(mst, 1); #1;
    if (mst == 1) begin
      rd = m1_if.rdata; rr = m1_if.rresp;
      if (!m1_if.rvalid) hold_ok = 0;
      if (m0_if.rvalid || m0_if.rdata != 0 || m0_if.rresp != 0) leak = 1;
    end else begin
      rd = m0_if.rdata; rr = m0_if.rresp;
      if (!m0_if.rvalid) hold_ok = 0;
      if (m1_if.rvalid || m1_if.rdata != 0 || m1_if.rresp != 0) leak = 1;
    end
    if (!s_if.rready) hold_ok = 0;
    @(negedge aclk);
    s_if.rvalid = 0; s_if.rdata = '0; s_if.rresp = '0;
    m0_if.rready = 0; m1_if.rready = 0;
  endtask

  task automatic test_reset();
    logic [31:0] outs;
    @(negedge aclk);
    areset = 1;
    m0_if.arvalid = 1; m0_if.araddr = 32'h1234_0000;
    #2;
    outs = {28'd0, s_if.arvalid, s_if.rready, m0_if.arready, m1_if.arready};
    checks++;
    if (outs !== 32'd0) begin
      errors++; $display("FAIL reset_ctrl: got %0h want 0", outs);
    end
    checks++;
    if (s_if.araddr !== 32'd0) begin
      errors++; $display("FAIL reset_araddr: got %0h want 0", s_if.araddr);
    end
    outs = {24'd0, m0_if.rvalid, m1_if.rvalid, m0_if.rresp, m1_if.rresp, 2'b00};
    checks++;
    if (outs !== 32'd0 || m0_if.rdata !== 0 || m1_if.rdata !== 0) begin
      errors++; $display("FAIL reset_rch: got %0h/%0h/%0h want 0", outs, m0_if.rdata,
                         m1_if.rdata);
    end
    m0_if.arvalid = 0;
    @(negedge aclk);
    areset = 0;
    last_m = 1;
  endtask

  task automatic test_single();
    int lat, mst; logic [31:0] addr, rd; logic [1:0] rr; bit leak, mok, hok;
    @(negedge aclk);
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0000;
    serve(0, 0, 32'hDEAD_BEEF, 2'b00, lat, mst, addr, rd, rr, leak, mok, hok);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL single_latency: got %0d want 1", lat); end
    checks++;
    if (mst !== 0 || addr !== 32'h8000_0000) begin
      errors++; $display("FAIL single_grant: got m%0d %0h want m0 80000000", mst, addr);
    end
    checks++;
    if (rd !== 32'hDEAD_BEEF || leak) begin
      errors++; $display("FAIL single_rdata: got %0h leak=%0d want deadbeef leak=0", rd, leak);
    end
    #1;
    checks++;
    if (s_if.arvalid || m0_if.rvalid || m1_if.rvalid) begin
      errors++; $display("FAIL single_idle: got arv=%0d rv0=%0d rv1=%0d want 0",
                         s_if.arvalid, m0_if.rvalid, m1_if.rvalid);
    end
    last_m = 0;
  endtask

  task automatic test_simultaneous();
    int lat, mst; logic [31:0] addr, rd; logic [1:0] rr; bit leak, mok, hok;
    @(negedge aclk);
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0004;
    m1_if.arvalid = 1; m1_if.araddr = 32'h8000_1000;
    serve(0, 0, 32'h0000_0A0A, 2'b00, lat, mst, addr, rd, rr, leak, mok, hok);
    checks++;
    if (mst !== 0 || addr !== 32'h8000_0004) begin
      errors++; $display("FAIL simul_first: got m%0d %0h want m0 80000004", mst, addr);
    end
    serve(0, 0, 32'h0000_0B0B, 2'b00, lat, mst, addr, rd, rr, leak, mok, hok);
    checks++;
    if (mst !== 1 || addr !== 32'h8000_1000 || lat !== 1) begin
      errors++; $display("FAIL simul_second: got m%0d %0h lat=%0d want m1 80001000 lat=1",
                         mst, addr, lat);
    end
    last_m = 1;
  endtask

  task automatic test_back_to_back();
    int lat, mst, exp; logic [31:0] addr, rd; logic [1:0] rr; bit leak, mok, hok;
    bit pend [2];
    logic [31:0] a [2];
    @(negedge aclk);
    a[0] = 32'h8000_2000; a[1] = 32'h8000_3000;
    m0_if.arvalid = 1; m0_if.araddr = a[0];
    m1_if.arvalid = 1; m1_if.araddr = a[1];
    pend[0] = 1; pend[1] = 1;
    for (int i = 0; i < 6; i++) begin
      exp = predict(pend[0], pend[1], last_m);
      serve(0, 0, a[exp] ^ 32'hFFFF_FFFF, 2'b00, lat, mst, addr, rd, rr, leak, mok, hok);
      checks++;
      if (mst !== exp || addr !== a[exp] || rd !== (a[exp] ^ 32'hFFFF_FFFF)) begin
        errors++; $display("FAIL b2b_%0d: got m%0d %0h rd=%0h want m%0d %0h", i, mst, addr,
                           rd, exp, a[exp]);
      end
      last_m = exp;
      pend[exp] = 0;
      if (i < 4) begin
        a[exp] = a[exp] + 32'h10;
        pend[exp] = 1;
        if (exp == 1) begin m1_if.arvalid = 1; m1_if.araddr = a[1]; end
        else begin m0_if.arvalid = 1; m0_if.araddr = a[0]; end
      end
    end
  endtask

  task automatic test_stall();
    int lat, mst; logic [31:0] addr, rd; logic [1:0] rr; bit leak, mok, hok;
    @(negedge aclk);
    m1_if.arvalid = 1; m1_if.araddr = 32'h8000_4000;
    serve(3, 2, 32'hCAFE_F00D, 2'b00, lat, mst, addr, rd, rr, leak, mok, hok);
    checks++;
    if (mst !== 1 || !mok) begin
      errors++; $display("FAIL stall_arready: got m%0d mirror=%0d want m1 mirror=1", mst, mok);
    end
    checks++;
    if (!hok || rd !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL stall_hold: got hold=%0d rd=%0h want 1 cafef00d", hok, rd);
    end
    last_m = 1;
  endtask

  task automatic test_error();
    int lat, mst, exp; logic [31:0] addr, rd; logic [1:0] rr; bit leak, mok, hok;
    @(negedge aclk);
    m1_if.arvalid = 1; m1_if.araddr = 32'h8000_5000;
    serve(0, 0, 32'h0, 2'b10, lat, mst, addr, rd, rr, leak, mok, hok);
    checks++;
    if (mst !== 1 || rr !== 2'b10 || leak) begin
      errors++; $display("FAIL error_resp: got m%0d rresp=%0d leak=%0d want m1 2 leak=0",
                         mst, rr, leak);
    end
    last_m = 1;
    @(negedge aclk);
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_5004;
    m1_if.arvalid = 1; m1_if.araddr = 32'h8000_5008;
    exp = predict(1, 1, last_m);
    serve(0, 0, 32'h5555_AAAA, 2'b00, lat, mst, addr, rd, rr, leak, mok, hok);
    checks++;
    if (mst !== exp || rr !== 2'b00) begin
      errors++; $display("FAIL error_next: got m%0d rresp=%0d want m%0d 0", mst, rr, exp);
    end
    last_m = exp;
    exp = predict(exp == 1 ? 1 : 0, exp == 0 ? 1 : 0, last_m);
    serve(0, 0, 32'h6666_0000, 2'b00, lat, mst, addr, rd, rr, leak, mok, hok);
    checks++;
    if (mst !== exp) begin
      errors++; $display("FAIL error_drain: got m%0d want m%0d", mst, exp);
    end
    last_m = exp;
  endtask

  task automatic test_reset_mid_data();
    int lat, mst; logic [31:0] addr, rd; logic [1:0] rr; bit leak, mok, hok;
    // Leave last = m0 so a missing reset of 'last' would favour m1 afterwards.
    @(negedge aclk);
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_6000;
    serve(0, 0, 32'h1, 2'b00, lat, mst, addr, rd, rr, leak, mok, hok);
    last_m = 0;
    m1_if.arvalid = 1; m1_if.araddr = 32'h8000_6100;
    @(negedge aclk);
    s_if.arready = 1;
    @(negedge aclk);
    s_if.arready = 0; m1_if.arvalid = 0;
    s_if.rvalid = 1; s_if.rdata = 32'h1234_5678; m1_if.rready = 1;
    #1;
    checks++;
    if (!m1_if.rvalid || !s_if.rready || m1_if.rdata !== 32'h1234_5678) begin
      errors++; $display("FAIL rstmid_pre: got rv=%0d rr=%0d rd=%0h want 1 1 12345678",
                         m1_if.rvalid, s_if.rready, m1_if.rdata);
    end
    areset = 1;
    #1;
    checks++;
    if (m1_if.rvalid || s_if.rready || m1_if.rdata !== 0 || s_if.arvalid) begin
      errors++; $display("FAIL rstmid_async: got rv=%0d rr=%0d rd=%0h arv=%0d want 0",
                         m1_if.rvalid, s_if.rready, m1_if.rdata, s_if.arvalid);
    end
    @(negedge aclk);
    areset = 0;
    s_if.rvalid = 0; s_if.rdata = '0; m1_if.rready = 0;
    last_m = 1;
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_7000;
    m1_if.arvalid = 1; m1_if.araddr = 32'h8000_7004;
    serve(0, 0, 32'h2, 2'b00, lat, mst, addr, rd, rr, leak, mok, hok);
    checks++;
    if (mst !== predict(1, 1, last_m) || addr !== 32'h8000_7000) begin
      errors++; $display("FAIL rstmid_first: got m%0d %0h want m0 80007000", mst, addr);
    end
    last_m = 0;
    serve(0, 0, 32'h3, 2'b00, lat, mst, addr, rd, rr, leak, mok, hok);
    last_m = 1;
  endtask

  task automatic test_random();
    int lat, mst, exp, ars, rrs; logic [31:0] addr, rd, data; logic [1:0] rr, resp;
    bit leak, mok, hok;
    bit pend [2];
    logic [31:0] a [2];
    pend[0] = 0; pend[1] = 0;
    for (int i = 0; i < 40; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (!pend[m] && $urandom_range(0, 1) == 1) begin
          pend[m] = 1; a[m] = $urandom & 32'hFFFF_FFFC;
        end
      end
      if (!pend[0] && !pend[1]) begin
        int m = $urandom_range(0, 1);
        pend[m] = 1; a[m] = $urandom & 32'hFFFF_FFFC;
      end
      m0_if.arvalid = pend[0]; m0_if.araddr = a[0];
      m1_if.arvalid = pend[1]; m1_if.araddr = a[1];
      exp  = predict(pend[0], pend[1], last_m);
      ars  = $urandom_range(0, 3);
      rrs  = $urandom_range(0, 3);
      data = $urandom;
      resp = 2'($urandom_range(0, 3));
      serve(ars, rrs, data, resp, lat, mst, addr, rd, rr, leak, mok, hok);
      checks++;
      if (lat !== 1 || mst !== exp || addr !== a[exp]) begin
        errors++; $display("FAIL rand_ar_%0d: got lat=%0d m%0d %0h want 1 m%0d %0h", i, lat,
                           mst, addr, exp, a[exp]);
      end
      checks++;
      if (rd !== data || rr !== resp || leak || !mok || !hok) begin
        errors++; $display("FAIL rand_r_%0d: got %0h/%0d l%0d m%0d h%0d want %0h/%0d", i, rd,
                           rr, leak, mok, hok, data, resp);
      end
      pend[exp] = 0;
      last_m = exp;
    end
  endtask

  initial begin
    areset = 1;
    m0_if.arvalid = 0; m0_if.araddr = '0; m0_if.rready = 0;
    m1_if.arvalid = 0; m1_if.araddr = '0; m1_if.rready = 0;
    s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.rresp = '0;
    last_m = 1;
    test_reset();
    test_single();
    do_reset();
    test_simultaneous();
    test_back_to_back();
    test_stall();
    test_error();
    test_reset_mid_data();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
